// File: rtl/bid_grant_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bid_pkg
// Description : Shared widths, types and helpers for the bid/grant scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package bid_pkg;

  localparam int N_MSTR = 4;
  localparam int BID_W  = 4;
  localparam int BAL_W  = 16;
  localparam int AGE_W  = 4;
  localparam int TO_W   = 8;
  localparam int ID_W   = 2;
  localparam int RP_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  typedef logic [BID_W-1:0] bid_t;
  typedef logic [BAL_W-1:0] bal_t;
  typedef logic [AGE_W-1:0] age_t;
  typedef logic [ID_W-1:0]  mid_t;

  // Add a credit to a balance at one extra bit, then clip at the ceiling.
  function automatic bal_t sat_add(input bal_t a, input bal_t b, input bal_t ceil_v);
    logic [BAL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, ceil_v}) begin
      return ceil_v;
    end
    return sum[BAL_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bid_grant_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : bid_grant_scheduler_if
// Description : Request/grant handshake between masters and the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface bid_grant_scheduler_if;
  import bid_pkg::*;

  logic [N_MSTR-1:0]       req_vld;
  logic [N_MSTR*BID_W-1:0] req_bid;
  logic [N_MSTR-1:0]       done;
  logic [N_MSTR-1:0]       grant;
  mid_t                    grant_id;
  logic                    busy;
  logic                    timeout_pulse;

  modport master (
    output req_vld, req_bid, done,
    input  grant, grant_id, busy, timeout_pulse
  );

  modport slave (
    input  req_vld, req_bid, done,
    output grant, grant_id, busy, timeout_pulse
  );

endinterface
`default_nettype wire

// File: rtl/bid_grant_scheduler_pick.sv
`default_nettype none
// ============================================================================
// Module      : bid_pick
// Description : Combinational 4-way highest-bid selector. A master is
//               eligible when valid and able to afford its bid; ties go to
//               the older master, then to the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
module bid_pick
  import bid_pkg::*;
(
  input  logic [N_MSTR-1:0] vld,
  input  bid_t              bid     [N_MSTR],
  input  bal_t              balance [N_MSTR],
  input  age_t              age     [N_MSTR],
  output logic              win_vld,
  output mid_t              win_id
);

  bid_t best_bid;
  age_t best_age;

  // Ascending scan with strict comparisons keeps the lowest index on a full tie.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    best_bid = '0;
    best_age = '0;
    for (int i = 0; i < N_MSTR; i++) begin
      if (vld[i] && (balance[i] >= {{(BAL_W-BID_W){1'b0}}, bid[i]})) begin
        if (!win_vld || (bid[i] > best_bid) ||
            ((bid[i] == best_bid) && (age[i] > best_age))) begin
          win_vld  = 1'b1;
          win_id   = i[ID_W-1:0];
          best_bid = bid[i];
          best_age = age[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bid_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bid_grant_scheduler
// Description : Credit-based bidding arbiter for a shared slave bus. Picks
//               one winner, holds its grant until done or timeout, charges
//               its bid and periodically refills all balances.
// Revision    : 1.0 - initial release
// ============================================================================
module bid_grant_scheduler
  import bid_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,               // active-low, asynchronous
  bid_grant_scheduler_if.slave    bus,
  input  bal_t                    cfg_refill_amt,
  input  logic [RP_W-1:0]         cfg_refill_period,
  input  bal_t                    cfg_max_bal,
  input  bal_t                    cfg_init_bal,
  input  logic [TO_W-1:0]         cfg_timeout,
  output logic [N_MSTR*BAL_W-1:0] balance
);

  sched_state_e      state_q;
  logic [N_MSTR-1:0] grant_q;
  mid_t              grant_id_q;
  logic              busy_q;
  logic              to_pulse_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [RP_W-1:0]   rf_cnt_q;
  bal_t              bal_q [N_MSTR];
  bal_t              bal_d [N_MSTR];
  age_t              age_q [N_MSTR];
  age_t              age_d [N_MSTR];
  bid_t              bids  [N_MSTR];

  logic win_vld;
  mid_t win_id;
  logic grant_edge;
  logic refill_hit;
  logic to_last;

  generate
    for (genvar gi = 0; gi < N_MSTR; gi++) begin : g_lane
      assign bids[gi]                   = bus.req_bid[gi*BID_W +: BID_W];
      assign balance[gi*BAL_W +: BAL_W] = bal_q[gi];
    end
  endgenerate

  bid_pick u_pick (
    .vld     (bus.req_vld),
    .bid     (bids),
    .balance (bal_q),
    .age     (age_q),
    .win_vld (win_vld),
    .win_id  (win_id)
  );

  assign grant_edge = (state_q == IDLE) && win_vld;
  assign refill_hit = (cfg_refill_period != '0) &&
                      (rf_cnt_q == cfg_refill_period - RP_W'(1));
  assign to_last    = (cfg_timeout != '0) &&
                      (to_cnt_q == cfg_timeout - TO_W'(1));

  // Next balance/age: charge the winner first, then apply any refill on top.
  always_comb begin : credit_next
    bal_t charged;
    charged = '0;
    for (int i = 0; i < N_MSTR; i++) begin
      charged = bal_q[i];
      age_d[i] = age_q[i];
      if (grant_edge) begin
        if (win_id == i[ID_W-1:0]) begin
          charged  = bal_q[i] - {{(BAL_W-BID_W){1'b0}}, bids[i]};
          age_d[i] = '0;
        end else if (bus.req_vld[i] && (age_q[i] != '1)) begin
          age_d[i] = age_q[i] + age_t'(1);
        end
      end
      bal_d[i] = refill_hit ? sat_add(charged, cfg_refill_amt, cfg_max_bal) : charged;
    end
  end

  // Balances, ages and the free-running refill counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_MSTR; i++) begin
        bal_q[i] <= cfg_init_bal;
        age_q[i] <= '0;
      end
      rf_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_MSTR; i++) begin
        bal_q[i] <= bal_d[i];
        age_q[i] <= age_d[i];
      end
      rf_cnt_q <= refill_hit ? '0 : rf_cnt_q + RP_W'(1);
    end
  end

  // Grant state machine with registered grant, busy and timeout outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      to_pulse_q <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      to_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q    <= HOLD;
            grant_q    <= N_MSTR'(1) << win_id;
            grant_id_q <= win_id;
            busy_q     <= 1'b1;
            to_cnt_q   <= '0;
          end
        end
        HOLD: begin
          if (bus.done[grant_id_q]) begin
            state_q <= GAP;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (to_last) begin
            state_q    <= GAP;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            to_pulse_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.busy          = busy_q;
  assign bus.timeout_pulse = to_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_bid_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bid_grant_scheduler
// Description : Scoreboard bench for bid_grant_scheduler. Expected winners are
//               queued when a request is driven and popped on each new grant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bid_grant_scheduler;
  import bid_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  bal_t                    cfg_refill_amt;
  logic [RP_W-1:0]         cfg_refill_period;
  bal_t                    cfg_max_bal;
  bal_t                    cfg_init_bal;
  logic [TO_W-1:0]         cfg_timeout;
  logic [N_MSTR*BAL_W-1:0] balance;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic [N_MSTR-1:0] prev_grant = '0;

  bid_grant_scheduler_if bus();

  bid_grant_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .cfg_refill_amt    (cfg_refill_amt),
    .cfg_refill_period (cfg_refill_period),
    .cfg_max_bal       (cfg_max_bal),
    .cfg_init_bal      (cfg_init_bal),
    .cfg_timeout       (cfg_timeout),
    .balance           (balance)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bal_t bal(input int i);
    return balance[i*BAL_W +: BAL_W];
  endfunction

  // Scoreboard: every rising grant must match the oldest queued winner.
  always @(negedge clk) begin
    int e;
    if (!rst) begin
      prev_grant = '0;
    end else begin
      if ((bus.grant != '0) && (prev_grant == '0)) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 32'(bus.grant), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_grant", 32'(bus.grant), 32'(4'b0001 << e));
          chk("sb_id", 32'(bus.grant_id), 32'(e));
        end
      end
      prev_grant = bus.grant;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b0;
    bus.req_vld = '0;
    bus.req_bid = '0;
    bus.done    = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive one request, queue the expected winner, confirm 1-cycle latency.
  task automatic arb(input logic [3:0] vld, input logic [15:0] bids, input int exp_id);
    @(negedge clk);
    bus.req_vld = vld;
    bus.req_bid = bids;
    exp_q.push_back(exp_id);
    @(negedge clk);
    chk("grant_latency", 32'(bus.busy), 32'd1);
    bus.req_vld = '0;
  endtask

  // Complete the current transfer and let the GAP cycle pass.
  task automatic finish(input int id);
    @(negedge clk);
    bus.done     = '0;
    bus.done[id] = 1'b1;
    @(negedge clk);
    bus.done = '0;
    chk("gap_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_age[4];
    rst               = 1'b0;
    bus.req_vld       = '0;
    bus.req_bid       = '0;
    bus.done          = '0;
    cfg_refill_amt    = 16'd0;
    cfg_refill_period = 16'd0;
    cfg_max_bal       = 16'd1000;
    cfg_init_bal      = 16'd100;
    cfg_timeout       = 8'd0;

    // Reset state
    do_reset();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_id", 32'(bus.grant_id), 32'd0);
    chk("rst_pulse", 32'(bus.timeout_pulse), 32'd0);
    for (int i = 0; i < N_MSTR; i++) chk("rst_bal", 32'(bal(i)), 32'd100);

    // Unique winner: bids {3,9,5,1}
    arb(4'b1111, 16'h1593, 1);
    chk("uniq_bal1", 32'(bal(1)), 32'd91);
    chk("uniq_bal0", 32'(bal(0)), 32'd100);
    exp_age = '{1, 0, 1, 1};
    for (int i = 0; i < N_MSTR; i++) chk("uniq_age", 32'(dut.age_q[i]), 32'(exp_age[i]));
    finish(1);

    // Age tie-break: build ages m0=2, m2=5 while master 3 wins
    cfg_init_bal = 16'd200;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      arb((r < 2) ? 4'b1101 : 4'b1100, (r < 2) ? 16'hF101 : 16'hF100, 3);
      finish(3);
    end
    chk("tie_age0", 32'(dut.age_q[0]), 32'd2);
    chk("tie_age2", 32'(dut.age_q[2]), 32'd5);
    arb(4'b0101, 16'h0707, 2);
    chk("tie_age0_after", 32'(dut.age_q[0]), 32'd3);
    chk("tie_age2_after", 32'(dut.age_q[2]), 32'd0);
    finish(2);
    arb(4'b0101, 16'h0707, 0);
    finish(0);
    chk("tie_bal3", 32'(bal(3)), 32'd125);
    chk("tie_bal0", 32'(bal(0)), 32'd193);
    chk("tie_bal2", 32'(bal(2)), 32'd193);

    // Insufficient balance, then refill makes master 3 eligible
    cfg_init_bal      = 16'd4;
    cfg_refill_amt    = 16'd10;
    cfg_refill_period = 16'd40;
    do_reset();
    @(negedge clk);
    bus.req_vld = 4'b1000;
    bus.req_bid = 16'h8000;
    @(negedge clk);
    @(negedge clk);
    chk("no_elig_busy", 32'(bus.busy), 32'd0);
    chk("no_elig_grant", 32'(bus.grant), 32'd0);
    bus.req_vld = '0;
    arb(4'b1001, 16'h8002, 0);
    finish(0);
    chk("poor_bal0", 32'(bal(0)), 32'd2);
    chk("poor_bal3", 32'(bal(3)), 32'd4);
    for (int k = 0; (k < 60) && (bal(3) != 16'd14); k++) @(negedge clk);
    chk("refill_bal3", 32'(bal(3)), 32'd14);
    chk("refill_bal0", 32'(bal(0)), 32'd12);
    arb(4'b1001, 16'h8002, 3);
    chk("rich_bal3", 32'(bal(3)), 32'd6);
    finish(3);
    cfg_refill_period = 16'd0;
    cfg_refill_amt    = 16'd0;

    // Timeout after 5 cycles, request held for re-arbitration
    cfg_init_bal = 16'd100;
    cfg_timeout  = 8'd5;
    do_reset();
    @(negedge clk);
    bus.req_vld = 4'b0010;
    bus.req_bid = 16'h0040;
    exp_q.push_back(1);
    exp_q.push_back(1);
    @(negedge clk);
    chk("to_bal_first", 32'(bal(1)), 32'd96);
    for (int k = 0; k < 5; k++) begin
      chk("to_hold_busy", 32'(bus.busy), 32'd1);
      chk("to_hold_pulse", 32'(bus.timeout_pulse), 32'd0);
      @(negedge clk);
    end
    chk("to_gap_busy", 32'(bus.busy), 32'd0);
    chk("to_gap_grant", 32'(bus.grant), 32'd0);
    chk("to_pulse", 32'(bus.timeout_pulse), 32'd1);
    @(negedge clk);
    chk("to_pulse_low", 32'(bus.timeout_pulse), 32'd0);
    chk("to_idle_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("to_rearb_busy", 32'(bus.busy), 32'd1);
    chk("to_no_refund", 32'(bal(1)), 32'd92);
    bus.req_vld = '0;
    finish(1);
    cfg_timeout = 8'd0;

    // Refill coinciding with a charge of 6 on balance 50
    cfg_init_bal      = 16'd50;
    cfg_refill_amt    = 16'd10;
    cfg_refill_period = 16'd8;
    do_reset();
    repeat (6) @(negedge clk);
    arb(4'b0001, 16'h0006, 0);
    chk("coin_bal0", 32'(bal(0)), 32'd54);
    chk("coin_bal1", 32'(bal(1)), 32'd60);
    finish(0);

    // Saturation at the ceiling, then a lowered ceiling applied at next refill
    cfg_init_bal      = 16'd995;
    cfg_refill_period = 16'd4;
    do_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < N_MSTR; i++) chk("sat_bal", 32'(bal(i)), 32'd1000);
    cfg_max_bal = 16'd998;
    @(negedge clk);
    chk("ceil_wait", 32'(bal(0)), 32'd1000);
    repeat (3) @(negedge clk);
    chk("ceil_clip0", 32'(bal(0)), 32'd998);
    chk("ceil_clip3", 32'(bal(3)), 32'd998);
    cfg_max_bal       = 16'd1000;
    cfg_refill_period = 16'd0;
    cfg_refill_amt    = 16'd0;

    // Zero balance with zero bid is still eligible
    cfg_init_bal = 16'd0;
    do_reset();
    arb(4'b0100, 16'h0000, 2);
    finish(2);
    chk("zero_bal2", 32'(bal(2)), 32'd0);

    // Asynchronous reset during HOLD
    cfg_init_bal = 16'd100;
    do_reset();
    arb(4'b0001, 16'h0005, 0);
    chk("hold_bal0", 32'(bal(0)), 32'd95);
    #2;
    rst = 1'b0;
    #1;
    chk("async_grant", 32'(bus.grant), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_bal0", 32'(bal(0)), 32'd100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
